comparator_serial_85: RTL and testbench

- Multi-cycle magnitude comparator for wide words.
- Compares two WIDTH-bit operands one nybble per clock, LSB nybble first. Each nybble step is a 74x85-equivalent slice, and its result feeds back as the cascade input of the next step.
- Used where a wide compare is needed without a combinational chain of 85 slices, e.g. address/limit checks off the critical path.
- Also presents the 85 cascade-input interface, so one instance can extend an external 85 chain.

---
 rtl/comparator_serial_85.sv | 138 +++++++++++++
 tb/tb_comparator_serial_85.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial_85.sv
// ---------------------------------------------------------------------------
// comparator_serial_85
//
// Multi-cycle unsigned magnitude comparator. It compares two WIDTH-bit words
// one nybble per clock, starting with the least-significant nybble. Each step
// is a 74x85-equivalent slice, and that step's result becomes the cascade
// input of the next step. The external 85 cascade inputs (igt/ilt/ieq) seed
// the first step, so one instance can extend an existing 85 chain.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   start  : request a compare (sampled only while idle)
//   a, b   : operands, latched on an accepted start
//   igt/ilt/ieq : cascade inputs, latched on an accepted start
//   busy   : high while a compare is in progress (exactly NYB cycles)
//   done   : one-cycle pulse in the cycle the result registers update
//   ogt/olt/oeq : registered result {A>B, A<B, A=B}
// ---------------------------------------------------------------------------
module comparator_serial_85 #(
    parameter int WIDTH = 16,
    parameter int NYB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             igt,
    input  logic             ilt,
    input  logic             ieq,
    output logic             busy,
    output logic             done,
    output logic             ogt,
    output logic             olt,
    output logic             oeq
);

    localparam int IW = (NYB > 1) ? $clog2(NYB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NYB - 1);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic             r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_casc;
    logic             r_done;
    logic [2:0]       r_res;

    logic [3:0]       w_a_nyb;
    logic [3:0]       w_b_nyb;
    logic [2:0]       w_slice;
    logic             w_last;

    // One 74x85 slice. Result encoding is {gt, lt, eq}.
    function automatic logic [2:0] slice85(input logic [3:0] an,
                                           input logic [3:0] bn,
                                           input logic [2:0] c);
        logic [2:0] r;
        if (an > bn) begin
            r = 3'b100;
        end else if (an < bn) begin
            r = 3'b010;
        end else if (c[0]) begin
            // Any cascade with ieq set resolves to equality.
            r = 3'b001;
        end else begin
            case (c[2:1])
                2'b00:   r = 3'b110;
                2'b01:   r = 3'b010;
                2'b10:   r = 3'b100;
                default: r = 3'b000;
            endcase
        end
        return r;
    endfunction

    // Operands are shifted right one nybble per step, so the slice under
    // evaluation always sits in the low nybble.
    always_comb begin
        w_a_nyb = r_a[3:0];
        w_b_nyb = r_b[3:0];
        w_last  = (r_idx == LAST_IDX);
        // After the first step an equal nybble simply carries the running
        // result forward. For normal one-hot codes this is identical to the
        // slice function; for the abnormal external codes (000/110) it keeps
        // an all-equal word from toggling 110<->000 on every step, so the
        // whole word behaves as a single wide 85 slice.
        if ((w_a_nyb == w_b_nyb) && (r_idx != '0)) begin
            w_slice = r_casc;
        end else begin
            w_slice = slice85(w_a_nyb, w_b_nyb, r_casc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_res   <= 3'b000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_casc  <= {igt, ilt, ieq};
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_casc <= w_slice;
                    r_a    <= r_a >> 4;
                    r_b    <= r_b >> 4;
                    r_idx  <= r_idx + 1'b1;
                    if (w_last) begin
                        r_res   <= w_slice;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign ogt  = r_res[2];
    assign olt  = r_res[1];
    assign oeq  = r_res[0];

endmodule

// File: tb/tb_comparator_serial_85.sv
// ---------------------------------------------------------------------------
// tb_comparator_serial_85
//
// Directed and random checks of comparator_serial_85. A WIDTH=16 instance
// covers the main behaviour; a WIDTH=4 instance gets an exhaustive sweep of
// every operand/cascade combination. Expected results are pushed to a queue
// when a compare is started and popped when the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_comparator_serial_85;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, igt, ilt, ieq;
    logic [15:0] a, b;
    logic        busy, done, ogt, olt, oeq;

    logic        start4, igt4, ilt4, ieq4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, ogt4, olt4, oeq4;

    int checks = 0;
    int errors = 0;
    int n_txn  = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp4_q[$];

    comparator_serial_85 #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .igt(igt), .ilt(ilt), .ieq(ieq),
        .busy(busy), .done(done), .ogt(ogt), .olt(olt), .oeq(oeq)
    );

    comparator_serial_85 #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .igt(igt4), .ilt(ilt4), .ieq(ieq4),
        .busy(busy4), .done(done4), .ogt(ogt4), .olt(olt4), .oeq(oeq4)
    );

    // Reference: whole-word unsigned compare; equal words map the cascade
    // through the 85 truth table.
    function automatic logic [2:0] model(input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic [2:0]  c);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        case (c)
            3'd0: return 3'b110;
            3'd1: return 3'b001;
            3'd2: return 3'b010;
            3'd3: return 3'b001;
            3'd4: return 3'b100;
            3'd5: return 3'b001;
            3'd6: return 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("dut16 spurious done", {15'd0, done}, 16'd0);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                n_txn++;
                $display("txn16 %0d result=%b expected=%b", n_txn, {ogt, olt, oeq}, e);
                chk("dut16 result", {13'd0, ogt, olt, oeq}, {13'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                chk("dut4 spurious done", {15'd0, done4}, 16'd0);
            end else begin
                logic [2:0] e;
                e = exp4_q.pop_front();
                $display("txn4 result=%b expected=%b", {ogt4, olt4, oeq4}, e);
                chk("dut4 result", {13'd0, ogt4, olt4, oeq4}, {13'd0, e});
            end
        end
    end

    // Drive a one-cycle start on dut16 and record the expected result.
    task automatic start16(input logic [15:0] x, input logic [15:0] y,
                           input logic [2:0] c, input bit push);
        a = x; b = y; {igt, ilt, ieq} = c;
        start = 1'b1;
        if (push) exp_q.push_back(model(x, y, c));
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for the done cycle of dut16.
    task automatic wait_done16();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("dut16 done timeout", {15'd0, done}, 16'd1);
    endtask

    task automatic run_cmp(input logic [15:0] x, input logic [15:0] y, input logic [2:0] c);
        start16(x, y, c, 1'b1);
        wait_done16();
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; igt = 0; ilt = 0; ieq = 0;
        start4 = 1'b0; a4 = '0; b4 = '0; igt4 = 0; ilt4 = 0; ieq4 = 0;
        tick(); tick();
        chk("reset busy", {15'd0, busy}, 16'd0);
        chk("reset done", {15'd0, done}, 16'd0);
        chk("reset outs", {13'd0, ogt, olt, oeq}, 16'd0);
        reset = 1'b0;
        tick();

        // Equal words, normal cascade: busy exactly 4 cycles then done.
        start16(16'h1234, 16'h1234, 3'b001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("latency busy", {15'd0, busy}, 16'd1);
            chk("latency no early done", {15'd0, done}, 16'd0);
            tick();
        end
        chk("latency busy low", {15'd0, busy}, 16'd0);
        chk("latency done", {15'd0, done}, 16'd1);
        tick();
        chk("done one cycle", {15'd0, done}, 16'd0);

        // MSB nybble decides; low nybble F>0 must not win.
        run_cmp(16'h8000, 16'h7FFF, 3'b001);
        run_cmp(16'h00FF, 16'h0100, 3'b001);

        // All eight cascade codes on an equal word.
        for (int c = 0; c < 8; c++) run_cmp(16'hBEEF, 16'hBEEF, 3'(c));

        // start while busy is ignored; operand changes after start ignored.
        start16(16'h0001, 16'h0002, 3'b001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = 16'hF000 + 16'(i); b = 16'h0000; start = 1'b1;
            tick();
        end
        start = 1'b0; a = 16'hFFFF; b = 16'h0000; {igt, ilt, ieq} = 3'b100;
        begin
            int nd = 0;
            for (int i = 0; i < 8; i++) begin
                if (done === 1'b1) nd++;
                tick();
            end
            chk("single done while busy", 16'(nd), 16'd1);
        end

        // Reset on the second RUN cycle aborts without a done pulse.
        start16(16'h00F0, 16'h0F00, 3'b001, 1'b0);
        tick();
        chk("abort in run", {15'd0, busy}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", {15'd0, busy}, 16'd0);
        chk("abort done", {15'd0, done}, 16'd0);
        chk("abort outs", {13'd0, ogt, olt, oeq}, 16'd0);
        begin
            int nd = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (done === 1'b1) nd++;
            end
            chk("no done after abort", 16'(nd), 16'd0);
        end
        run_cmp(16'h0000, 16'h0000, 3'b001);

        // start held high: new compare accepted on the edge ending done.
        a = 16'h4000; b = 16'h3FFF; {igt, ilt, ieq} = 3'b001;
        start = 1'b1;
        exp_q.push_back(model(16'h4000, 16'h3FFF, 3'b001));
        tick();
        wait_done16();
        chk("held start idle in done", {15'd0, busy}, 16'd0);
        exp_q.push_back(model(16'h4000, 16'h3FFF, 3'b001));
        tick();
        start = 1'b0;
        chk("held start restart", {15'd0, busy}, 16'd1);
        wait_done16();
        tick();

        // Exhaustive WIDTH=4 sweep at single-step latency.
        for (int v = 0; v < 2048; v++) begin
            logic [10:0] vv;
            vv = 11'(v);
            a4 = vv[3:0]; b4 = vv[7:4]; {igt4, ilt4, ieq4} = vv[10:8];
            exp4_q.push_back(model({12'd0, vv[3:0]}, {12'd0, vv[7:4]}, vv[10:8]));
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            if (busy4 !== 1'b1) chk("dut4 busy", {15'd0, busy4}, 16'd1);
            tick();
            if (done4 !== 1'b1) chk("dut4 done latency", {15'd0, done4}, 16'd1);
            tick();
        end
        chk("dut4 queue drained", 16'(exp4_q.size()), 16'd0);

        // Random WIDTH=16 compares, biased toward shared upper nybbles.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] x, y;
            logic [3:0]  m;
            x = 16'($urandom);
            y = 16'($urandom);
            m = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) if (m[k]) y[4*k +: 4] = x[4*k +: 4];
            run_cmp(x, y, 3'($urandom_range(0, 7)));
        end

        tick(); tick();
        chk("dut16 queue drained", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
